// File: rtl/lenet_predict_mul_pipe_if.sv
// Operand/result bundle for the pipelined MAC-lane multiplier.
// master drives ce/din0/din1/in_valid; slave returns dout/out_valid/sat_flag.
interface lenet_predict_mul_pipe_if #(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26
);
  logic                  ce;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  in_valid;
  logic [dout_WIDTH-1:0] dout;
  logic                  out_valid;
  logic                  sat_flag;

  modport master (
    output ce, din0, din1, in_valid,
    input  dout, out_valid, sat_flag
  );

  modport slave (
    input  ce, din0, din1, in_valid,
    output dout, out_valid, sat_flag
  );
endinterface

// File: rtl/lenet_predict_mul_pipe.sv
// Pipelined signed/unsigned multiplier with wrap/saturate, ce stall, valid tag.
// Ports: clk, reset (sync, active-high), io (slave: ce, din0, din1, in_valid -> dout, out_valid, sat_flag).
module lenet_predict_mul_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int SAT_MODE    = 0
) (
  input logic                    clk,
  input logic                    reset,
  lenet_predict_mul_pipe_if.slave io
);

  localparam int D0W = din0_WIDTH;
  localparam int D1W = din1_WIDTH;
  localparam int DW  = dout_WIDTH;
  localparam int P   = D0W + D1W + 2;
  localparam int WW  = ((P > DW) ? P : DW) + 1;
  localparam int NR  = (NUM_STAGE == 1) ? 1 : NUM_STAGE - 1;
  localparam bit RS  = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  localparam logic signed [WW-1:0] ONE  = {{(WW-1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0] UMAX = (ONE << DW) - ONE;
  localparam logic signed [WW-1:0] SMAX = (ONE << (DW - 1)) - ONE;
  localparam logic signed [WW-1:0] SMIN = ~SMAX;

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
    $error("mul_pipe %0d: NUM_STAGE out of range", ID);
  end
  if (D0W < 1 || D0W > 32) begin : g_bad_w0
    $error("mul_pipe %0d: din0_WIDTH out of range", ID);
  end
  if (D1W < 1 || D1W > 32) begin : g_bad_w1
    $error("mul_pipe %0d: din1_WIDTH out of range", ID);
  end
  if (DW < 1 || DW > 64) begin : g_bad_wo
    $error("mul_pipe %0d: dout_WIDTH out of range", ID);
  end

  logic signed [D0W:0] a_x;
  logic signed [D1W:0] b_x;
  logic signed [D0W:0] src_a;
  logic signed [D1W:0] src_b;
  logic                src_v;

  // One extra bit makes every operand a signed value of its own range.
  always_comb begin
    a_x = {(DIN0_SIGNED != 0) & io.din0[D0W-1], io.din0};
    b_x = {(DIN1_SIGNED != 0) & io.din1[D1W-1], io.din1};
  end

  // A single-stage pipe has nowhere to park operands, so the
  // multiply sits in front of the only (output) register.
  if (NUM_STAGE == 1) begin : g_op_bypass
    assign src_a = a_x;
    assign src_b = b_x;
    assign src_v = io.in_valid;
  end else begin : g_op_reg
    logic signed [D0W:0] a_q, a_d;
    logic signed [D1W:0] b_q, b_d;
    logic                v_q, v_d;

    always_comb begin
      a_d = a_q;
      b_d = b_q;
      v_d = v_q;
      if (io.ce) begin
        a_d = a_x;
        b_d = b_x;
        v_d = io.in_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        v_q <= 1'b0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        v_q <= v_d;
      end
    end

    assign src_a = a_q;
    assign src_b = b_q;
    assign src_v = v_q;
  end

  logic signed [P-1:0]  ax;
  logic signed [P-1:0]  bx;
  logic signed [P-1:0]  prod;
  logic signed [WW-1:0] wide;
  logic [DW-1:0]        red_d;
  logic                 red_s;

  // Product is exact in P bits; widening by one more bit lets the
  // unsigned all-ones limit compare as a positive signed value.
  always_comb begin
    ax    = {{(P-D0W-1){src_a[D0W]}}, src_a};
    bx    = {{(P-D1W-1){src_b[D1W]}}, src_b};
    prod  = ax * bx;
    wide  = {{(WW-P){prod[P-1]}}, prod};
    red_d = wide[DW-1:0];
    red_s = 1'b0;
    if (SAT_MODE != 0) begin
      if (!RS) begin
        if (wide > UMAX) begin
          red_d = '1;
          red_s = 1'b1;
        end
      end else if (wide > SMAX) begin
        red_d = SMAX[DW-1:0];
        red_s = 1'b1;
      end else if (wide < SMIN) begin
        red_d = SMIN[DW-1:0];
        red_s = 1'b1;
      end
    end
  end

  logic [NR-1:0][DW-1:0] res_q, res_d;
  logic [NR-1:0]         vld_q, vld_d;
  logic [NR-1:0]         sat_q, sat_d;

  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    sat_d = sat_q;
    if (io.ce) begin
      res_d[0] = red_d;
      vld_d[0] = src_v;
      sat_d[0] = red_s & src_v;
      for (int i = 1; i < NR; i++) begin
        res_d[i] = res_q[i-1];
        vld_d[i] = vld_q[i-1];
        sat_d[i] = sat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      vld_q <= '0;
      sat_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end

  assign io.dout      = res_q[NR-1];
  assign io.out_valid = vld_q[NR-1];
  assign io.sat_flag  = sat_q[NR-1];

endmodule

// File: tb/tb_lenet_predict_mul_pipe.sv
// Bench for lenet_predict_mul_pipe: four configurations against a queue model.
// Directed literal cases, stall, streaming and mid-flight reset.
module tb_lenet_predict_mul_pipe;

  typedef struct {
    bit          chk;
    bit          v;
    logic [63:0] d;
    bit          s;
  } exp_t;

  localparam int NSA [4] = '{3, 2, 1, 4};
  localparam int W0A [4] = '{14, 8, 8, 8};
  localparam int W1A [4] = '{12, 8, 8, 8};
  localparam int DWA [4] = '{26, 8, 8, 16};
  localparam int S0A [4] = '{0, 1, 1, 1};
  localparam int S1A [4] = '{0, 1, 1, 0};
  localparam int STA [4] = '{0, 1, 0, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  longint d0 [4];
  longint d1 [4];
  logic   iv [4];
  logic [63:0] od [4];
  logic        ov [4];
  logic        os [4];
  exp_t q [4][$];
  int n_pass = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  lenet_predict_mul_pipe_if #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26)) if0 ();
  lenet_predict_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8)) if1 ();
  lenet_predict_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8)) if2 ();
  lenet_predict_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16)) if3 ();

  assign if0.ce = ce;
  assign if1.ce = ce;
  assign if2.ce = ce;
  assign if3.ce = ce;
  assign if0.din0 = d0[0][13:0];
  assign if0.din1 = d1[0][11:0];
  assign if1.din0 = d0[1][7:0];
  assign if1.din1 = d1[1][7:0];
  assign if2.din0 = d0[2][7:0];
  assign if2.din1 = d1[2][7:0];
  assign if3.din0 = d0[3][7:0];
  assign if3.din1 = d1[3][7:0];
  assign if0.in_valid = iv[0];
  assign if1.in_valid = iv[1];
  assign if2.in_valid = iv[2];
  assign if3.in_valid = iv[3];
  assign od[0] = 64'(if0.dout);
  assign od[1] = 64'(if1.dout);
  assign od[2] = 64'(if2.dout);
  assign od[3] = 64'(if3.dout);
  assign ov[0] = if0.out_valid;
  assign ov[1] = if1.out_valid;
  assign ov[2] = if2.out_valid;
  assign ov[3] = if3.out_valid;
  assign os[0] = if0.sat_flag;
  assign os[1] = if1.sat_flag;
  assign os[2] = if2.sat_flag;
  assign os[3] = if3.sat_flag;

  lenet_predict_mul_pipe #(
    .NUM_STAGE(3), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26),
    .DIN0_SIGNED(0), .DIN1_SIGNED(0), .SAT_MODE(0)
  ) u0 (.clk(clk), .reset(reset), .io(if0));

  lenet_predict_mul_pipe #(
    .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SAT_MODE(1)
  ) u1 (.clk(clk), .reset(reset), .io(if1));

  lenet_predict_mul_pipe #(
    .NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SAT_MODE(0)
  ) u2 (.clk(clk), .reset(reset), .io(if2));

  lenet_predict_mul_pipe #(
    .NUM_STAGE(4), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
    .DIN0_SIGNED(1), .DIN1_SIGNED(0), .SAT_MODE(0)
  ) u3 (.clk(clk), .reset(reset), .io(if3));

  function automatic logic [63:0] msk(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Plain integer arithmetic on the operand values, then the dout rule.
  task automatic ref_mul(
    input longint ar, input longint br,
    input int w0, input int w1, input int dw,
    input int s0, input int s1, input int sat,
    output logic [63:0] d, output bit f
  );
    longint a, b, p, mx, mn;
    a = ar;
    b = br;
    if (s0 != 0 && ar[w0-1]) a = ar - (longint'(1) << w0);
    if (s1 != 0 && br[w1-1]) b = br - (longint'(1) << w1);
    p = a * b;
    f = 1'b0;
    d = 64'(p) & msk(dw);
    if (sat != 0 && dw < w0 + w1) begin
      if (s0 == 0 && s1 == 0) begin
        mx = (longint'(1) << dw) - 1;
        if (p > mx) begin d = msk(dw); f = 1'b1; end
      end else begin
        mx = (longint'(1) << (dw - 1)) - 1;
        mn = -mx - 1;
        if (p > mx) begin
          d = 64'(mx) & msk(dw); f = 1'b1;
        end else if (p < mn) begin
          d = 64'(mn) & msk(dw); f = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int k,
                     input logic [63:0] got, input logic [63:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d got=%0h want=%0h", nm, k, got, want);
  endtask

  task automatic drive(input int k, input longint a, input longint b, input bit v);
    d0[k] = longint'(64'(a) & msk(W0A[k]));
    d1[k] = longint'(64'(b) & msk(W1A[k]));
    iv[k] = v;
  endtask

  // Model: one queue per DUT, NUM_STAGE deep, advanced only on ce edges.
  always @(posedge clk) begin
    exp_t        e;
    logic [63:0] d;
    bit          f;
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        q[k].delete();
        for (int i = 0; i < NSA[k]; i++) begin
          e.chk = 1'b1; e.v = 1'b0; e.d = '0; e.s = 1'b0;
          q[k].push_back(e);
        end
      end else if (ce && q[k].size() != 0) begin
        ref_mul(d0[k], d1[k], W0A[k], W1A[k], DWA[k],
                S0A[k], S1A[k], STA[k], d, f);
        e.chk = iv[k];
        e.v   = iv[k];
        e.d   = iv[k] ? d : '0;
        e.s   = iv[k] && f;
        q[k].push_back(e);
        void'(q[k].pop_front());
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() != 0) begin
        e = q[k][0];
        chk("out_valid", k, 64'(ov[k]), 64'(e.v));
        chk("sat_flag", k, 64'(os[k]), 64'(e.s));
        if (e.chk) chk("dout", k, od[k], e.d);
      end
    end
  end

  task automatic issue_and_check(input int k, input longint a, input longint b,
                                 input logic [63:0] wd, input bit ws);
    @(negedge clk);
    drive(k, a, b, 1'b1);
    @(negedge clk);
    iv[k] = 1'b0;
    repeat (NSA[k] - 1) @(posedge clk);
    #1;
    chk("lit_valid", k, 64'(ov[k]), 64'd1);
    chk("lit_dout", k, od[k], wd);
    chk("lit_sat", k, 64'(os[k]), 64'(ws));
  endtask

  initial begin
    logic [63:0] pd;
    bit          pf;
    longint      a, b;

    for (int k = 0; k < 4; k++) drive(k, 0, 0, 1'b0);

    ref_mul(16383, 4095, 14, 12, 26, 0, 0, 0, pd, pf);
    chk("pin_dflt", 0, pd, 64'd67088385);
    ref_mul(128, 128, 8, 8, 8, 1, 1, 1, pd, pf);
    chk("pin_ssat", 1, pd, 64'h7F);
    chk("pin_ssat_f", 1, 64'(pf), 64'd1);
    ref_mul(128, 128, 8, 8, 8, 1, 1, 0, pd, pf);
    chk("pin_wrap", 2, pd, 64'h00);
    ref_mul(255, 255, 8, 8, 16, 1, 0, 0, pd, pf);
    chk("pin_mixed", 3, pd, 64'hFF01);

    repeat (3) @(negedge clk);
    chk("rst_dout", 0, od[0], 64'd0);
    chk("rst_valid", 0, 64'(ov[0]), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue_and_check(0, 16383, 4095, 64'd67088385, 1'b0);
    issue_and_check(1, 128, 128, 64'h7F, 1'b1);
    issue_and_check(1, 128, 1, 64'h80, 1'b0);
    issue_and_check(2, 128, 128, 64'h00, 1'b0);
    issue_and_check(2, 128, 1, 64'h80, 1'b0);
    issue_and_check(3, 255, 255, 64'hFF01, 1'b0);

    // Stall while a valid result (35) is on the output; junk inputs ignored.
    @(negedge clk);
    drive(0, 5, 7, 1'b1);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    drive(0, 2, 3, 1'b1);
    @(negedge clk);
    ce = 1'b0;
    drive(0, 100, 100, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_dout", 0, od[0], 64'd35);
      chk("stall_valid", 0, 64'(ov[0]), 64'd1);
    end
    ce = 1'b1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_gap", 0, 64'(ov[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("stall_valid3", 0, 64'(ov[0]), 64'd1);
    chk("stall_dout3", 0, od[0], 64'd6);

    // Back-to-back streaming with boundary operands mixed in.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        case (i % 10)
          0: begin a = longint'(msk(W0A[k])); b = longint'(msk(W1A[k])); end
          1: begin a = longint'(1) << (W0A[k] - 1); b = longint'(1) << (W1A[k] - 1); end
          2: begin a = longint'(1) << (W0A[k] - 1); b = longint'(msk(W1A[k])); end
          default: begin a = longint'($urandom); b = longint'($urandom); end
        endcase
        drive(k, a, b, 1'b1);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) iv[k] = 1'b0;
    repeat (6) @(negedge clk);

    // Reset with products in flight: none of them may emerge.
    drive(0, 3, 4, 1'b1);
    drive(3, 3, 4, 1'b1);
    @(negedge clk);
    drive(0, 6, 7, 1'b1);
    drive(3, 6, 7, 1'b1);
    @(negedge clk);
    drive(0, 1, 1, 1'b1);
    drive(3, 1, 1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    iv[0] = 1'b0;
    iv[3] = 1'b0;
    chk("midrst_dout", 0, od[0], 64'd0);
    chk("midrst_valid", 0, 64'(ov[0]), 64'd0);
    chk("midrst_sat", 1, 64'(os[1]), 64'd0);
    repeat (6) @(negedge clk);
    issue_and_check(0, 9, 9, 64'd81, 1'b0);
    issue_and_check(3, 254, 3, 64'hFFFA, 1'b0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lenet_predict_mul_pipe.md
Name: lenet_predict_mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for the lenet_predict datapath (conv/FC MAC lanes).
- Generalises the single-cycle unsigned multiplier primitive with:
  - configurable pipeline depth;
  - per-operand signedness;
  - a wrap or saturate output mode;
  - a clock-enable stall;
  - valid tagging, so schedulers can track results without counting cycles.

Parameters:
ID, 1, instance tag, no functional effect
NUM_STAGE, 3, pipeline registers from input to output, legal range 1..8
din0_WIDTH, 14, operand 0 width, 1..32
din1_WIDTH, 12, operand 1 width, 1..32
dout_WIDTH, 26, result width, 1..64
DIN0_SIGNED, 0, 1 = din0 is two's complement, 0 = unsigned
DIN1_SIGNED, 0, 1 = din1 is two's complement, 0 = unsigned
SAT_MODE, 0, 0 = wrap (keep LSBs), 1 = saturate to dout range

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
ce  input  1  clock enable; 0 freezes every pipeline register
din0  input  din0_WIDTH  operand 0
din1  input  din1_WIDTH  operand 1
in_valid  input  1  operands valid this cycle
dout  output  dout_WIDTH  product
out_valid  output  1  dout holds the product of a valid input
sat_flag  output  1  dout was clamped (SAT_MODE=1 only, else constant 0)

Behaviour:
- Reset: the design has one clock; reset is synchronous and active-high.
  - On a clk edge with reset=1, every pipeline data register, every valid bit and every flag bit clears to 0, regardless of ce.
  - Outputs read dout=0, out_valid=0, sat_flag=0 from the following cycle.
  - Reset mid-operation discards all in-flight products; no out_valid pulse is produced for them.
- Operand extension:
  - Each operand is extended by one bit: sign extension if its SIGNED parameter is 1, zero extension otherwise.
  - The extended operands are multiplied as signed values, width P = din0_WIDTH+din1_WIDTH+2.
  - The product is always exact; no overflow is possible inside P.
- Result signedness: RS = DIN0_SIGNED | DIN1_SIGNED.
- Width reduction:
  - dout_WIDTH >= P-2: the result is extended to dout_WIDTH (sign-extended if RS, else zero-extended).
  - Otherwise, with SAT_MODE=0: dout takes the low dout_WIDTH bits (modular wrap, identical to the existing combinational mul primitive).
  - Otherwise, with SAT_MODE=1 and RS=0: a result > 2^dout_WIDTH-1 clamps to all-ones.
  - Otherwise, with SAT_MODE=1 and RS=1: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - sat_flag=1 for exactly the beat whose value was clamped.
- Pipeline:
  - Stage 1 registers the operands.
  - The multiply and width-reduction logic may be retimed across stages 1..NUM_STAGE.
  - dout, out_valid and sat_flag are driven directly from registers of the final stage; there is no combinational path from any input to any output.
  - Latency: an input captured on a ce=1 edge with in_valid=1 appears at the output after exactly NUM_STAGE ce=1 edges, with out_valid=1.
  - Throughput: one product per ce=1 cycle.
- Clock enable:
  - ce=0 holds all registers; dout, out_valid and sat_flag stay stable for the whole stall.
  - Inputs presented while ce=0 are ignored.
  - A stall has no effect on pipeline ordering.
- in_valid=0 beats:
  - They propagate as bubbles: out_valid=0 at the corresponding output slot.
  - Data registers may update with don't-care values; the bench checks dout only when out_valid=1.
  - sat_flag is qualified by out_valid and reads 0 on bubbles.
- Elaboration checks: an illegal parameter (NUM_STAGE=0, any width out of range) causes an elaboration error.

Test Plan:
- Defaults (unsigned, 14x12->26, NUM_STAGE=3): din0=16383, din1=4095 with in_valid=1, ce=1 -> 3 edges later dout=67,088,385, out_valid=1; out_valid=0 on all other cycles.
- Back-to-back streaming: 100 random valid operand pairs, ce=1 -> 100 consecutive out_valid beats in input order, each matching a reference model.
- Stall: issue 2x3, then hold ce=0 for 5 cycles, then ce=1 -> dout and out_valid are frozen during the stall, and dout=6 arrives after the 3rd ce=1 edge counted from issue.
- Signed saturate (DIN0_SIGNED=1, DIN1_SIGNED=1, 8x8->8, SAT_MODE=1):
  - -128 x -128 -> dout=127, sat_flag=1.
  - -128 x 1 -> dout=-128, sat_flag=0.
  - Same operands with SAT_MODE=0 -> 16384 wraps to dout=0, and -128 x 1 gives dout=-128.
- Mixed signedness (din0 signed 8-bit, din1 unsigned 8-bit, dout 16): -1 x 255 -> dout=0xFF01 (-255), not 0xFEFF... confirm sign path.
- Reset mid-flight: issue 3 valid beats, assert reset for 1 cycle after the 2nd edge -> out_valid stays 0 for all of them, dout=0, sat_flag=0; the next valid input after reset is produced NUM_STAGE ce=1 edges later with the correct value.
